// File: rtl/sisc_ctrl_pkg.sv
// sisc_ctrl shared definitions: opcodes, IR fields,
// FSM state encoding and decoded-instruction bundle.
package sisc_ctrl_pkg;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 28;
   localparam int MM_MSB = 27;
   localparam int MM_LSB = 24;
   localparam int FN_MSB = 3;
   localparam int FN_LSB = 0;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LOD = 4'h1;
   localparam logic [3:0] OP_STR = 4'h2;
   localparam logic [3:0] OP_BRA = 4'h4;
   localparam logic [3:0] OP_BRR = 4'h5;
   localparam logic [3:0] OP_ALU = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [3:0] ALU_ADD = 4'h1;

   typedef enum logic [2:0] {
      S_START,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WB,
      S_HALT
   } state_e;

   typedef struct packed {
      logic       alu;
      logic       lod;
      logic       str;
      logic       br;
      logic       nop;
      logic       hlt;
      logic       taken;
      logic       imm;
      logic       rel;
      logic [3:0] func;
   } dec_t;

endpackage

// File: rtl/sisc_ctrl_if.sv
// Control-unit to datapath signal bundle.
// master = control unit, slave = datapath side.
interface sisc_ctrl_if #(
   parameter int RCNT_W = 16
);
   logic [31:0]       ir;
   logic [3:0]        stat;
   logic              mem_ack;
   logic              ir_load;
   logic              pc_write;
   logic              pc_sel;
   logic              br_sel;
   logic              rf_we;
   logic              wb_sel;
   logic [3:0]        alu_op;
   logic              alu_src;
   logic              stat_en;
   logic              mem_req;
   logic              mem_we;
   logic              halted;
   logic              fault;
   logic [RCNT_W-1:0] retired;

   modport master (
      input  ir, stat, mem_ack,
      output ir_load, pc_write, pc_sel, br_sel,
      output rf_we, wb_sel, alu_op, alu_src,
      output stat_en, mem_req, mem_we,
      output halted, fault, retired
   );

   modport slave (
      output ir, stat, mem_ack,
      input  ir_load, pc_write, pc_sel, br_sel,
      input  rf_we, wb_sel, alu_op, alu_src,
      input  stat_en, mem_req, mem_we,
      input  halted, fault, retired
   );
endinterface

// File: rtl/sisc_ctrl_decode.sv
// Instruction classifier: opcode to one-hot class,
// plus branch-taken condition and operand fields.
module sisc_ctrl_decode
   import sisc_ctrl_pkg::*;
(
   input  logic [31:0] ir_i,
   input  logic [3:0]  stat_i,
   output dec_t        dec_o
);

   logic [3:0] op;
   logic [3:0] mm;
   logic       unused_ir;

   assign op = ir_i[OP_MSB:OP_LSB];
   assign mm = ir_i[MM_MSB:MM_LSB];
   assign unused_ir = ^ir_i[MM_LSB-1:FN_MSB+1];

   // Unlisted opcodes fall into the NOP class.
   always_comb begin
      dec_o       = '0;
      dec_o.taken = |(mm & stat_i);
      dec_o.imm   = mm[3];
      dec_o.rel   = op[0];
      dec_o.func  = ir_i[FN_MSB:FN_LSB];
      unique case (op)
         OP_LOD:         dec_o.lod = 1'b1;
         OP_STR:         dec_o.str = 1'b1;
         OP_BRA, OP_BRR: dec_o.br  = 1'b1;
         OP_ALU:         dec_o.alu = 1'b1;
         OP_HLT:         dec_o.hlt = 1'b1;
         default:        dec_o.nop = 1'b1;
      endcase
   end

endmodule

// File: rtl/sisc_ctrl.sv
// sisc multi-cycle control unit: FSM, memory wait
// counter with timeout fault, retired counter.
module sisc_ctrl
   import sisc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 8,
   parameter int RCNT_W      = 16
) (
   input  logic       CLK,
   input  logic       RST,
   sisc_ctrl_if.master bus
);

   localparam int CW = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [CW-1:0] WLAST = CW'(MEM_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [CW-1:0]     wcnt_q, wcnt_d;
   logic [RCNT_W-1:0] ret_q, ret_d;
   logic              fault_q, fault_d;
   dec_t              dec;

   sisc_ctrl_decode u_dec (
      .ir_i   (bus.ir),
      .stat_i (bus.stat),
      .dec_o  (dec)
   );

   assign bus.fault   = fault_q;
   assign bus.retired = ret_q;

   // State and counters; reset abandons any access.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_START;
         wcnt_q  <= '0;
         ret_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         ret_q   <= ret_d;
         fault_q <= fault_d;
      end
   end

   // Next state and datapath enables per state.
   always_comb begin
      state_d      = state_q;
      wcnt_d       = '0;
      ret_d        = ret_q;
      fault_d      = fault_q;
      bus.ir_load  = 1'b0;
      bus.pc_write = 1'b0;
      bus.pc_sel   = 1'b0;
      bus.br_sel   = 1'b0;
      bus.rf_we    = 1'b0;
      bus.wb_sel   = 1'b0;
      bus.alu_op   = 4'h0;
      bus.alu_src  = 1'b0;
      bus.stat_en  = 1'b0;
      bus.mem_req  = 1'b0;
      bus.mem_we   = 1'b0;
      bus.halted   = 1'b0;
      unique case (state_q)
         S_START: state_d = S_FETCH;
         S_FETCH: begin
            bus.ir_load  = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = S_DECODE;
         end
         S_DECODE: begin
            state_d = dec.hlt ? S_HALT : S_EXECUTE;
         end
         S_EXECUTE: begin
            bus.alu_op = ALU_ADD;
            unique case (1'b1)
               dec.alu: begin
                  bus.alu_op  = dec.func;
                  bus.alu_src = dec.imm;
                  bus.stat_en = 1'b1;
                  state_d     = S_WB;
               end
               dec.lod, dec.str: state_d = S_MEM;
               dec.br: begin
                  bus.pc_write = dec.taken;
                  bus.pc_sel   = dec.taken;
                  bus.br_sel   = dec.taken & dec.rel;
                  state_d      = S_FETCH;
                  ret_d        = ret_q + 1'b1;
               end
               default: begin
                  state_d = S_FETCH;
                  ret_d   = ret_q + 1'b1;
               end
            endcase
         end
         S_MEM: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = dec.str;
            wcnt_d      = wcnt_q + 1'b1;
            if (bus.mem_ack) begin
               wcnt_d = '0;
               if (dec.lod) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
                  ret_d   = ret_q + 1'b1;
               end
            end else if (wcnt_q == WLAST) begin
               wcnt_d  = '0;
               state_d = S_HALT;
               fault_d = 1'b1;
            end
         end
         S_WB: begin
            bus.rf_we  = 1'b1;
            bus.wb_sel = dec.lod;
            state_d    = S_FETCH;
            ret_d      = ret_q + 1'b1;
         end
         S_HALT: bus.halted = 1'b1;
         default: state_d = S_START;
      endcase
   end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Self-checking bench for sisc_ctrl: directed vector
// table, spec-level random model, reset/timeout cases.
module tb_sisc_ctrl;

   localparam int TO = 8;
   localparam int RW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   sisc_ctrl_if #(.RCNT_W(RW)) bus();

   sisc_ctrl #(
      .MEM_TIMEOUT (TO),
      .RCNT_W      (RW)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic          ir_load;
      logic          pc_write;
      logic          pc_sel;
      logic          br_sel;
      logic          rf_we;
      logic          wb_sel;
      logic [3:0]    alu_op;
      logic          alu_src;
      logic          stat_en;
      logic          mem_req;
      logic          mem_we;
      logic          halted;
      logic          fault;
      logic [RW-1:0] retired;
   } out_t;

   typedef struct {
      logic ack;
      out_t o;
   } ent_t;

   typedef struct {
      logic [31:0] ir;
      logic [3:0]  st;
      int ackn;
      int lat;
      int nreq;
      int nwe;
      int npcw;
      int nbrs;
      int nrfw;
      int nwbs;
      int nst;
      int rinc;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   logic [RW-1:0] ret_m;
   bit flt_m;
   bit halt_m;
   vec_t tbl[10];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic out_t smp();
      out_t o;
      o.ir_load  = bus.ir_load;
      o.pc_write = bus.pc_write;
      o.pc_sel   = bus.pc_sel;
      o.br_sel   = bus.br_sel;
      o.rf_we    = bus.rf_we;
      o.wb_sel   = bus.wb_sel;
      o.alu_op   = bus.alu_op;
      o.alu_src  = bus.alu_src;
      o.stat_en  = bus.stat_en;
      o.mem_req  = bus.mem_req;
      o.mem_we   = bus.mem_we;
      o.halted   = bus.halted;
      o.fault    = bus.fault;
      o.retired  = bus.retired;
      return o;
   endfunction

   task automatic chk_o(input string nm, input out_t e);
      chk(nm, 32'(smp()), 32'(e));
   endtask

   task automatic do_reset();
      out_t e;
      @(negedge clk);
      rst = 1'b1;
      bus.mem_ack = 1'b0;
      #1;
      e = '0;
      chk_o("rst_async", e);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_o("start", e);
      @(negedge clk);
      e.ir_load  = 1'b1;
      e.pc_write = 1'b1;
      chk_o("first_fetch", e);
      ret_m  = '0;
      flt_m  = 1'b0;
      halt_m = 1'b0;
   endtask

   // Reference: per-cycle expectations from the
   // instruction-class rules and latency table.
   task automatic run(input logic [31:0] ir,
                      input logic [3:0] st,
                      input int ackn,
                      input bit noise);
      ent_t q[$];
      ent_t e;
      out_t b;
      logic [3:0] op, mm, fn;
      bit ok;
      int nm;
      op = ir[31:28];
      mm = ir[27:24];
      fn = ir[3:0];
      b = '0;
      b.fault = flt_m;
      b.retired = ret_m;
      e.ack = 1'b0;
      e.o = b;
      e.o.ir_load = 1'b1;
      e.o.pc_write = 1'b1;
      q.push_back(e);
      e.o = b;
      q.push_back(e);
      if (op == 4'hF) begin
         e.o.halted = 1'b1;
         q.push_back(e);
         halt_m = 1'b1;
      end else begin
         e.o.alu_op = 4'h1;
         case (op)
            4'h8: begin
               e.o.alu_op = fn;
               e.o.alu_src = mm[3];
               e.o.stat_en = 1'b1;
               q.push_back(e);
               e.o = b;
               e.o.rf_we = 1'b1;
               q.push_back(e);
               ret_m = ret_m + 1'b1;
            end
            4'h1, 4'h2: begin
               q.push_back(e);
               ok = (ackn >= 1 && ackn <= TO);
               nm = ok ? ackn : TO;
               for (int k = 1; k <= nm; k++) begin
                  e.o = b;
                  e.o.mem_req = 1'b1;
                  e.o.mem_we = (op == 4'h2);
                  e.ack = (k == ackn);
                  q.push_back(e);
               end
               e.ack = 1'b0;
               e.o = b;
               if (!ok) begin
                  e.o.halted = 1'b1;
                  e.o.fault = 1'b1;
                  q.push_back(e);
                  halt_m = 1'b1;
                  flt_m = 1'b1;
               end else begin
                  if (op == 4'h1) begin
                     e.o.rf_we = 1'b1;
                     e.o.wb_sel = 1'b1;
                     q.push_back(e);
                  end
                  ret_m = ret_m + 1'b1;
               end
            end
            4'h4, 4'h5: begin
               if (|(mm & st)) begin
                  e.o.pc_write = 1'b1;
                  e.o.pc_sel = 1'b1;
                  e.o.br_sel = op[0];
               end
               q.push_back(e);
               ret_m = ret_m + 1'b1;
            end
            default: begin
               q.push_back(e);
               ret_m = ret_m + 1'b1;
            end
         endcase
      end
      foreach (q[i]) begin
         if (i > 0) @(negedge clk);
         if (i == 0) begin
            bus.ir = ir;
            bus.stat = st;
         end
         bus.mem_ack = q[i].ack |
            (noise && !q[i].o.mem_req &&
             $urandom_range(0, 3) == 0);
         chk_o($sformatf("run ir=%h c%0d", ir, i),
               q[i].o);
      end
      if (!halt_m) @(negedge clk);
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      int lat, nreq, nwe, npcw, nbrs;
      int nrfw, nwbs, nst;
      bit done;
      lat = 0; nreq = 0; nwe = 0; npcw = 0;
      nbrs = 0; nrfw = 0; nwbs = 0; nst = 0;
      done = 1'b0;
      bus.ir = v.ir;
      bus.stat = v.st;
      for (int c = 0; c < 40 && !done; c++) begin
         if (c > 0 && bus.ir_load) begin
            done = 1'b1;
         end else begin
            if (bus.mem_req) nreq++;
            bus.mem_ack = bus.mem_req && (nreq == v.ackn);
            nwe  += int'(bus.mem_we);
            npcw += int'(bus.pc_write);
            nbrs += int'(bus.br_sel);
            nrfw += int'(bus.rf_we);
            nwbs += int'(bus.wb_sel);
            nst  += int'(bus.stat_en);
            @(negedge clk);
            lat++;
         end
      end
      bus.mem_ack = 1'b0;
      ret_m = ret_m + RW'(v.rinc);
      chk($sformatf("v%0d done", idx), 32'(done), 32'd1);
      chk($sformatf("v%0d lat", idx), lat, v.lat);
      chk($sformatf("v%0d req", idx), nreq, v.nreq);
      chk($sformatf("v%0d we", idx), nwe, v.nwe);
      chk($sformatf("v%0d pcw", idx), npcw, v.npcw);
      chk($sformatf("v%0d brs", idx), nbrs, v.nbrs);
      chk($sformatf("v%0d rfw", idx), nrfw, v.nrfw);
      chk($sformatf("v%0d wbs", idx), nwbs, v.nwbs);
      chk($sformatf("v%0d st", idx), nst, v.nst);
      chk($sformatf("v%0d ret", idx),
          32'(bus.retired), 32'(ret_m));
   endtask

   initial begin
      logic [31:0] r;
      logic [3:0] op;
      out_t e;
      bus.ir = '0;
      bus.stat = '0;
      bus.mem_ack = 1'b0;
      ret_m = '0;
      flt_m = 1'b0;
      halt_m = 1'b0;

      tbl[0] = '{32'h80231002, 4'h0, 0, 4, 0, 0, 1, 0, 1, 0, 1, 1};
      tbl[1] = '{32'h8802000A, 4'h0, 0, 4, 0, 0, 1, 0, 1, 0, 1, 1};
      tbl[2] = '{32'h10000005, 4'h0, 3, 7, 3, 0, 1, 0, 1, 1, 0, 1};
      tbl[3] = '{32'h20000005, 4'h0, 3, 6, 3, 3, 1, 0, 0, 0, 0, 1};
      tbl[4] = '{32'h41000000, 4'h1, 0, 3, 0, 0, 2, 0, 0, 0, 0, 1};
      tbl[5] = '{32'h41000000, 4'h0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 1};
      tbl[6] = '{32'h53000000, 4'h2, 0, 3, 0, 0, 2, 1, 0, 0, 0, 1};
      tbl[7] = '{32'h00000000, 4'hF, 0, 3, 0, 0, 1, 0, 0, 0, 0, 1};
      tbl[8] = '{32'h7F000000, 4'hF, 0, 3, 0, 0, 1, 0, 0, 0, 0, 1};
      tbl[9] = '{32'h10000000, 4'h0, 1, 5, 1, 0, 1, 0, 1, 1, 0, 1};

      do_reset();

      for (int i = 0; i < 10; i++) apply_vec(tbl[i], i);

      for (int n = 0; n < 150; n++) begin
         r = $urandom();
         op = 4'($urandom_range(0, 14));
         r[31:28] = op;
         run(r, 4'($urandom_range(0, 15)),
             int'($urandom_range(1, 7)), 1'b1);
      end

      run(32'h20000000, 4'h0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.ir = 32'h80231002;
         bus.mem_ack = i[0];
         e = '0;
         e.halted = 1'b1;
         e.fault = 1'b1;
         e.retired = ret_m;
         chk_o($sformatf("to_halt%0d", i), e);
      end

      do_reset();
      run(32'h20000000, 4'h0, TO, 1'b0);
      run(32'h10000000, 4'h0, TO, 1'b0);
      chk("no_fault", 32'(bus.fault), 32'd0);
      run(32'hF0000000, 4'h0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.ir = 32'h20000000;
         bus.mem_ack = ~i[0];
         e = '0;
         e.halted = 1'b1;
         e.retired = ret_m;
         chk_o($sformatf("hlt%0d", i), e);
      end

      do_reset();
      bus.ir = 32'h20000000;
      bus.mem_ack = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_req", 32'(bus.mem_req), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_req_drop", 32'(bus.mem_req), 32'd0);
      chk("mid_we_drop", 32'(bus.mem_we), 32'd0);
      chk("mid_fault", 32'(bus.fault), 32'd0);
      do_reset();
      run(32'h80231002, 4'h0, 0, 1'b0);
      chk("final_ret", 32'(bus.retired), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sisc_ctrl.md
Name: sisc_ctrl

Overview:
Multi-cycle control unit for the sisc processor. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable: PC, IR, register file, ALU, status register and data memory. Data-memory accesses use a req/ack handshake with a bounded wait. It sits between the IR/status register and the datapath, beside the PC and register-file blocks.

Parameters:
MEM_TIMEOUT, 8, max cycles spent in MEM waiting for mem_ack before a fault halt
RCNT_W, 16, width of the retired-instruction counter

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
ir  input  32  current instruction: opcode[31:28], mm[27:24], func[3:0]
stat  input  4  ALU status register {C,N,V,Z}
mem_ack  input  1  data memory completed access (1-cycle pulse)
ir_load  output  1  load IR from instruction memory
pc_write  output  1  update PC
pc_sel  output  1  0 = PC+1, 1 = branch target
br_sel  output  1  0 = absolute target (BRA), 1 = relative target (BRR)
rf_we  output  1  register-file write enable
wb_sel  output  1  0 = ALU result, 1 = memory data
alu_op  output  4  ALU function: func for ALU ops; 4'h1 (add) otherwise
alu_src  output  1  1 = immediate operand (mm[3]=1)
stat_en  output  1  latch ALU flags into status register
mem_req  output  1  data-memory request
mem_we  output  1  write qualifier, valid only with mem_req
halted  output  1  in HALT state
fault  output  1  sticky: halted because of a memory timeout
retired  output  RCNT_W  count of completed instructions

Behaviour:
- Opcodes: 0 NOP, 1 LOD, 2 STR, 4 BRA, 5 BRR, 8 ALU, F HLT. Any other opcode executes as NOP.
- States: START, FETCH, DECODE, EXECUTE, MEM, WB, HALT. State is held in a register; outputs are combinational from the state register plus ir.
- RST asserted: state = START, wait counter = 0, retired = 0, fault = 0, immediately and regardless of clock. All enables and mem_req decode to 0 in START, so an in-flight memory access is abandoned without a write.
- START -> FETCH on the first clock after RST deasserts.
- FETCH: ir_load = 1, pc_write = 1, pc_sel = 0. Next state DECODE.
- DECODE: no enables asserted. HLT -> HALT. Otherwise -> EXECUTE.
- EXECUTE:
  - ALU: alu_op = func, alu_src = mm[3], stat_en = 1 -> WB.
  - LOD/STR: alu_op = add (address calculation) -> MEM.
  - BRA/BRR: taken = |(mm & stat). If taken, pc_write = 1, pc_sel = 1, br_sel = opcode[0]. Then -> FETCH.
  - NOP: -> FETCH.
- MEM:
  - mem_req = 1 throughout; mem_we = 1 for STR.
  - The wait counter increments each MEM cycle and clears on exit.
  - mem_ack: LOD -> WB, STR -> FETCH.
  - If the counter reaches MEM_TIMEOUT-1 without mem_ack: -> HALT and fault is set.
  - If mem_ack arrives in that same last cycle, mem_ack wins and there is no fault.
- WB: rf_we = 1; wb_sel = 1 for LOD, 0 for ALU. Next state FETCH.
- retired increments on every exit to FETCH from EXECUTE, MEM or WB. It wraps modulo 2^RCNT_W. HLT does not count.
- HALT: halted = 1, all enables 0. Left only by RST.
- Latency per instruction:
  - NOP/branch: 3 cycles.
  - ALU: 4 cycles.
  - STR: 3 + n cycles, where n = cycles to mem_ack (n >= 1).
  - LOD: 4 + n cycles.
- mem_ack outside MEM is ignored.

Decomposition:
- Shared package: opcode constants, state encoding, ALU func constants, IR field bit positions.
- One sub-module, sisc_ctrl_decode: combinational decode of opcode/mm/func into instruction class (alu, lod, str, br, nop, hlt) and the branch-taken condition. sisc_ctrl keeps the FSM, wait counter, retired counter and fault flag.

Test Plan:
- Reset: hold RST = 1 for 2 cycles, then release -> all outputs 0; START for 1 cycle, then FETCH with ir_load = 1 and pc_write = 1.
- ir = 32'h80231002 (ALU sub) -> EXECUTE: alu_op = 4'h2, stat_en = 1, alu_src = 0; WB: rf_we = 1, wb_sel = 0; retired increments by 1; 4 cycles FETCH-to-FETCH. With ir = 32'h8802000A, EXECUTE has alu_src = 1 and alu_op = 4'hA.
- LOD with mem_ack after 3 MEM cycles -> mem_req = 1 for exactly 3 cycles, mem_we = 0, then WB with rf_we = 1 and wb_sel = 1. Repeat as STR -> mem_we = 1, no WB, next state FETCH.
- Branches:
  - BRA with mm = 4'b0001, stat = 4'b0001 -> EXECUTE: pc_write = 1, pc_sel = 1, br_sel = 0.
  - Same with stat = 4'b0000 -> no pc_write.
  - BRR taken -> br_sel = 1.
- Memory timeout: STR with mem_ack never asserted -> after 8 MEM cycles, halted = 1 and fault = 1, retired unchanged. Repeat with mem_ack in the 8th cycle -> no fault.
- ir = 32'hF0000000 -> HALT after DECODE; mem_ack and ir changes have no effect. Assert RST mid-MEM on a later STR -> mem_req drops in the same timestep and fault clears.
